// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester main-memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {StIdle, StOwn, StDrain} arb_state_e;

   localparam logic REQ_I = 1'b0;
   localparam logic REQ_D = 1'b1;

   localparam int unsigned BANK_LSB  = 1;
   localparam int unsigned BANK_BITS = 2;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of both cache-controller ports plus the four-bank memory port.
// slave: arbiter view; master: requesters and memory model view.
interface mem_arbiter_if #(
   parameter int unsigned AW = 16,
   parameter int unsigned DW = 16
);
   logic          r0_req, r0_rd, r0_wr;
   logic [AW-1:0] r0_addr;
   logic [DW-1:0] r0_wdata;
   logic          r0_gnt, r0_stall, r0_rvalid;
   logic [DW-1:0] r0_rdata;

   logic          r1_req, r1_rd, r1_wr;
   logic [AW-1:0] r1_addr;
   logic [DW-1:0] r1_wdata;
   logic          r1_gnt, r1_stall, r1_rvalid;
   logic [DW-1:0] r1_rdata;

   logic          m_rd, m_wr;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [DW-1:0] m_rdata;
   logic [3:0]    m_busy;
   logic          m_err;
   logic          err;

   modport slave (
      input  r0_req, r0_rd, r0_wr, r0_addr, r0_wdata,
      input  r1_req, r1_rd, r1_wr, r1_addr, r1_wdata,
      input  m_rdata, m_busy, m_err,
      output r0_gnt, r0_stall, r0_rvalid, r0_rdata,
      output r1_gnt, r1_stall, r1_rvalid, r1_rdata,
      output m_rd, m_wr, m_addr, m_wdata, err
   );

   modport master (
      output r0_req, r0_rd, r0_wr, r0_addr, r0_wdata,
      output r1_req, r1_rd, r1_wr, r1_addr, r1_wdata,
      output m_rdata, m_busy, m_err,
      input  r0_gnt, r0_stall, r0_rvalid, r0_rdata,
      input  r1_gnt, r1_stall, r1_rvalid, r1_rdata,
      input  m_rd, m_wr, m_addr, m_wdata, err
   );
endinterface

// File: rtl/mem_arb_rd_track.sv
// Read-latency tracker: an RdLat-stage valid+tag shift register that flags
// which requester owns the read data returning this cycle.
module mem_arb_rd_track #(
   parameter int unsigned RdLat = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push_i,
   input  logic       tag_i,
   output logic       empty_o,
   output logic [1:0] rvalid_o
);

   logic [RdLat-1:0] vld_q, vld_d;
   logic [RdLat-1:0] tag_q, tag_d;

   always_comb begin
      vld_d = (vld_q << 1) | RdLat'(push_i);
      tag_d = (tag_q << 1) | RdLat'(tag_i);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q <= '0;
         tag_q <= '0;
      end else begin
         vld_q <= vld_d;
         tag_q <= tag_d;
      end
   end

   assign empty_o     = ~|vld_q;
   assign rvalid_o[0] = vld_q[RdLat-1] & ~tag_q[RdLat-1];
   assign rvalid_o[1] = vld_q[RdLat-1] &  tag_q[RdLat-1];

endmodule

// File: rtl/mem_arbiter.sv
// Transaction-level arbiter sharing the four-bank memory between I- and D-cache.
// MEM_ARB_DPRIO_EN: requester 1 wins every simultaneous contest (else round-robin).
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned RD_LAT = 2,
   parameter int unsigned AW     = 16,
   parameter int unsigned DW     = 16
) (
   input logic           clk,
   input logic           rst,
   mem_arbiter_if.slave  bus
);

   arb_state_e state_q, state_d;
   logic       owner_q, owner_d;
   logic       last_gnt_q, last_gnt_d;
   logic       err_q, err_d;

   logic [1:0]    req, rd, wr;
   logic [AW-1:0] addr [2];
   logic [DW-1:0] wdata [2];

   logic                 in_own, own_req, own_rd, own_wr, own_acc;
   logic [AW-1:0]        own_addr;
   logic [BANK_BITS-1:0] bank;
   logic                 bank_busy, issue, winner;
   logic                 trk_empty;
   logic [1:0]           trk_rvalid;

   assign req      = {bus.r1_req, bus.r0_req};
   assign rd       = {bus.r1_rd, bus.r0_rd};
   assign wr       = {bus.r1_wr, bus.r0_wr};
   assign addr[0]  = bus.r0_addr;
   assign addr[1]  = bus.r1_addr;
   assign wdata[0] = bus.r0_wdata;
   assign wdata[1] = bus.r1_wdata;

   always_comb begin
      in_own    = (state_q == StOwn);
      own_req   = req[owner_q];
      own_rd    = rd[owner_q];
      own_wr    = wr[owner_q];
      own_addr  = addr[owner_q];
      bank      = own_addr[BANK_LSB +: BANK_BITS];
      bank_busy = bus.m_busy[bank];
      // A dropping req cancels the access; rd&wr together is never issued.
      own_acc   = in_own & own_req & (own_rd ^ own_wr);
      issue     = own_acc & ~bank_busy & ~bus.m_err;
   end

   assign bus.m_rd    = issue & own_rd;
   assign bus.m_wr    = issue & own_wr;
   assign bus.m_addr  = issue ? own_addr : '0;
   assign bus.m_wdata = issue ? wdata[owner_q] : '0;

   assign bus.r0_gnt   = in_own & (owner_q == REQ_I);
   assign bus.r1_gnt   = in_own & (owner_q == REQ_D);
   assign bus.r0_stall = bus.r0_gnt ? (own_acc & bank_busy) : (bus.r0_rd | bus.r0_wr);
   assign bus.r1_stall = bus.r1_gnt ? (own_acc & bank_busy) : (bus.r1_rd | bus.r1_wr);

   assign bus.r0_rvalid = trk_rvalid[0];
   assign bus.r1_rvalid = trk_rvalid[1];
   assign bus.r0_rdata  = trk_rvalid[0] ? bus.m_rdata : '0;
   assign bus.r1_rdata  = trk_rvalid[1] ? bus.m_rdata : '0;
   assign bus.err       = err_q;

   mem_arb_rd_track #(
      .RdLat (RD_LAT)
   ) u_rd_track (
      .clk      (clk),
      .rst      (rst),
      .push_i   (issue & own_rd),
      .tag_i    (owner_q),
      .empty_o  (trk_empty),
      .rvalid_o (trk_rvalid)
   );

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      last_gnt_d = last_gnt_q;
      winner     = REQ_I;
      err_d      = bus.m_err | (in_own & own_req & own_rd & own_wr);

      if (req == 2'b11) begin
`ifdef MEM_ARB_DPRIO_EN
         winner = REQ_D;
`else
         winner = ~last_gnt_q;
`endif
      end else begin
         winner = req[1];
      end

      unique case (state_q)
         StIdle: begin
            if (|req) begin
               owner_d    = winner;
               last_gnt_d = winner;
               state_d    = StOwn;
            end
         end
         StOwn: begin
            if (!own_req) state_d = trk_empty ? StIdle : StDrain;
         end
         StDrain: begin
            if (trk_empty) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         owner_q    <= REQ_I;
         last_gnt_q <= REQ_D;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         last_gnt_q <= last_gnt_d;
         err_q      <= err_d;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic,
// all compared against a queue-based transaction model.
module tb_mem_arbiter;

   localparam int RD_LAT = 2;

   logic clk = 1'b0;
   logic rst;

   mem_arbiter_if #(.AW(16), .DW(16)) bus ();

   mem_arbiter #(
      .RD_LAT (RD_LAT),
      .AW     (16),
      .DW     (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Model: phase 0 = nobody owns, 1 = owned, 2 = waiting for reads to return.
   typedef struct {int due; int who;} rd_t;
   rd_t pend[$];
   int  m_phase, m_owner, m_last;
   bit  m_errp;
   int  n_phase, n_owner, n_last, push_who;
   bit  n_errp, n_push;
   logic [72:0] exp_v;

   function automatic logic [72:0] obs();
      return {bus.r0_gnt, bus.r0_stall, bus.r0_rvalid, bus.r0_rdata,
              bus.r1_gnt, bus.r1_stall, bus.r1_rvalid, bus.r1_rdata,
              bus.m_rd, bus.m_wr, bus.m_addr, bus.m_wdata, bus.err};
   endfunction

   task automatic model_reset();
      pend.delete();
      m_phase = 0; m_owner = 0; m_last = 1; m_errp = 1'b0; n_push = 1'b0;
   endtask

   task automatic model_eval();
      bit          req [2], rd [2], wr [2], g [2], st [2], rv [2];
      logic [15:0] addr [2], wd [2], rdat [2];
      bit          inflight, acc, busy, issue;
      int          o;
      req[0] = bus.r0_req; rd[0] = bus.r0_rd; wr[0] = bus.r0_wr;
      req[1] = bus.r1_req; rd[1] = bus.r1_rd; wr[1] = bus.r1_wr;
      addr[0] = bus.r0_addr; wd[0] = bus.r0_wdata;
      addr[1] = bus.r1_addr; wd[1] = bus.r1_wdata;
      while (pend.size() > 0 && pend[0].due < cyc) void'(pend.pop_front());
      inflight = pend.size() > 0;
      o = m_owner;
      for (int i = 0; i < 2; i++) begin
         g[i] = 0; st[i] = rd[i] | wr[i]; rv[i] = 0; rdat[i] = 16'h0;
      end
      acc = 0; issue = 0;
      if (m_phase == 1) begin
         g[o]  = 1;
         acc   = req[o] && (rd[o] != wr[o]);
         busy  = bus.m_busy[addr[o][2:1]];
         issue = acc && !busy && !bus.m_err;
         st[o] = acc && busy;
      end
      foreach (pend[j]) if (pend[j].due == cyc) begin
         rv[pend[j].who] = 1; rdat[pend[j].who] = bus.m_rdata;
      end
      exp_v = {g[0], st[0], rv[0], rdat[0], g[1], st[1], rv[1], rdat[1],
               issue && rd[o], issue && wr[o], issue ? addr[o] : 16'h0,
               issue ? wd[o] : 16'h0, m_errp};
      n_errp   = bus.m_err || (m_phase == 1 && req[o] && rd[o] && wr[o]);
      n_push   = issue && rd[o];
      push_who = o;
      n_phase = m_phase; n_owner = m_owner; n_last = m_last;
      case (m_phase)
         0: if (req[0] || req[1]) begin
            if (req[0] && req[1]) begin
`ifdef MEM_ARB_DPRIO_EN
               n_owner = 1;
`else
               n_owner = 1 - m_last;
`endif
            end else n_owner = req[1] ? 1 : 0;
            n_last = n_owner; n_phase = 1;
         end
         1: if (!req[o]) n_phase = inflight ? 2 : 0;
         default: if (!inflight) n_phase = 0;
      endcase
   endtask

   task automatic settle();
      @(negedge clk);
      model_eval();
   endtask

   task automatic advance();
      rd_t e;
      if (n_push) begin
         e.due = cyc + RD_LAT; e.who = push_who; pend.push_back(e);
      end
      m_phase = n_phase; m_owner = n_owner; m_last = n_last; m_errp = n_errp;
      @(posedge clk); #1;
      cyc++;
   endtask

   task automatic idle_inputs();
      bus.r0_req = 0; bus.r0_rd = 0; bus.r0_wr = 0; bus.r0_addr = '0; bus.r0_wdata = '0;
      bus.r1_req = 0; bus.r1_rd = 0; bus.r1_wr = 0; bus.r1_addr = '0; bus.r1_wdata = '0;
      bus.m_rdata = '0; bus.m_busy = '0; bus.m_err = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      cyc++;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if (obs() !== 73'h0) begin
         errors++; $display("FAIL reset_outputs got=%h exp=0", obs());
      end
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      settle();
      checks++;
      if (obs() !== exp_v) begin
         errors++; $display("FAIL reset_idle got=%h exp=%h", obs(), exp_v);
      end
      advance();
   endtask

   task automatic test_basic_read();
      logic [15:0] d;
      idle_inputs();
      bus.r0_req = 1; bus.r0_rd = 1; bus.r0_addr = 16'h0010;
      for (int k = 0; k < 6; k++) begin
         if (k == 2) bus.r0_rd = 0;
         if (k == 4) bus.r0_req = 0;
         d = 16'($urandom);
         bus.m_rdata = d;
         settle();
         checks++;
         if (obs() !== exp_v) begin
            errors++; $display("FAIL basic_read k=%0d got=%h exp=%h", k, obs(), exp_v);
         end
         if (k == 1) begin
            checks++;
            if ({bus.r0_gnt, bus.m_rd, bus.m_addr} !== {1'b1, 1'b1, 16'h0010}) begin
               errors++; $display("FAIL basic_issue got=%b%b_%h exp=11_0010",
                                  bus.r0_gnt, bus.m_rd, bus.m_addr);
            end
         end
         if (k == 3) begin
            checks++;
            if ({bus.r0_rvalid, bus.r0_rdata} !== {1'b1, d}) begin
               errors++; $display("FAIL basic_rvalid got=%b_%h exp=1_%h",
                                  bus.r0_rvalid, bus.r0_rdata, d);
            end
         end
         advance();
      end
   endtask

   task automatic test_round_robin();
      logic [1:0] first, second;
`ifdef MEM_ARB_DPRIO_EN
      first = 2'b10;
`else
      first = 2'b01;
`endif
      second = ~first;
      do_reset();
      bus.r0_req = 1; bus.r1_req = 1;
      for (int k = 0; k < 11; k++) begin
         if (k == 2) {bus.r1_req, bus.r0_req} = second;
         if (k == 5) {bus.r1_req, bus.r0_req} = 2'b00;
         if (k == 7) {bus.r1_req, bus.r0_req} = 2'b11;
         if (k == 9) {bus.r1_req, bus.r0_req} = 2'b00;
         settle();
         checks++;
         if (obs() !== exp_v) begin
            errors++; $display("FAIL rr_model k=%0d got=%h exp=%h", k, obs(), exp_v);
         end
         if (k == 1 || k == 3 || k == 4 || k == 8) begin
            checks++;
            if ({bus.r1_gnt, bus.r0_gnt} !== ((k == 3) ? 2'b00 : (k == 4) ? second : first)) begin
               errors++; $display("FAIL rr_gnt k=%0d got=%b", k, {bus.r1_gnt, bus.r0_gnt});
            end
         end
         advance();
      end
   endtask

   task automatic test_bank_busy();
      logic [15:0] d;
      d = 16'($urandom);
      idle_inputs();
      bus.r1_req = 1; bus.r1_wr = 1; bus.r1_addr = 16'h0006; bus.r1_wdata = d;
      bus.m_busy = 4'b1000;
      for (int k = 0; k < 7; k++) begin
         bus.r0_rd = (k == 2);
         if (k == 4) bus.m_busy = 4'b0000;
         if (k == 5) begin bus.r1_req = 0; bus.r1_wr = 0; end
         settle();
         checks++;
         if (obs() !== exp_v) begin
            errors++; $display("FAIL busy_model k=%0d got=%h exp=%h", k, obs(), exp_v);
         end
         if (k >= 1 && k <= 4) begin
            checks++;
            if ({bus.r1_stall, bus.m_wr} !== ((k == 4) ? 2'b01 : 2'b10)) begin
               errors++; $display("FAIL busy_stall k=%0d got=%b", k, {bus.r1_stall, bus.m_wr});
            end
         end
         advance();
      end
   endtask

   task automatic test_drain();
      logic [15:0] d;
      idle_inputs();
      bus.r0_req = 1; bus.r0_rd = 1; bus.r0_addr = 16'($urandom);
      for (int k = 0; k < 9; k++) begin
         if (k == 1) bus.r1_req = 1;
         if (k == 2) begin bus.r0_req = 0; bus.r0_rd = 0; end
         if (k == 7) bus.r1_req = 0;
         d = 16'($urandom);
         bus.m_rdata = d;
         settle();
         checks++;
         if (obs() !== exp_v) begin
            errors++; $display("FAIL drain_model k=%0d got=%h exp=%h", k, obs(), exp_v);
         end
         if (k == 3) begin
            checks++;
            if ({bus.r0_rvalid, bus.r0_rdata} !== {1'b1, d}) begin
               errors++; $display("FAIL drain_rvalid got=%b_%h exp=1_%h",
                                  bus.r0_rvalid, bus.r0_rdata, d);
            end
         end
         if (k >= 3 && k <= 6) begin
            checks++;
            if ({bus.r1_gnt, bus.r0_gnt} !== ((k == 6) ? 2'b10 : 2'b00)) begin
               errors++; $display("FAIL drain_gnt k=%0d got=%b", k, {bus.r1_gnt, bus.r0_gnt});
            end
         end
         advance();
      end
   endtask

   task automatic test_err();
      idle_inputs();
      bus.r0_req = 1;
      for (int k = 0; k < 7; k++) begin
         bus.r0_rd = (k == 1); bus.r0_wr = (k == 1);
         bus.m_err = (k == 3);
         if (k == 5) bus.r0_req = 0;
         settle();
         checks++;
         if (obs() !== exp_v) begin
            errors++; $display("FAIL err_model k=%0d got=%h exp=%h", k, obs(), exp_v);
         end
         if (k >= 1 && k <= 4) begin
            checks++;
            if ({bus.m_rd, bus.m_wr, bus.r0_stall, bus.err} !== {3'b000, (k == 2 || k == 4)}) begin
               errors++; $display("FAIL err_pulse k=%0d got=%b", k,
                                  {bus.m_rd, bus.m_wr, bus.r0_stall, bus.err});
            end
         end
         advance();
      end
   endtask

   task automatic test_random();
      idle_inputs();
      for (int k = 0; k < 400 + RD_LAT + 4; k++) begin
         if (k < 400) begin
            if ($urandom_range(5) == 0) bus.r0_req = ~bus.r0_req;
            if ($urandom_range(5) == 0) bus.r1_req = ~bus.r1_req;
            bus.r0_rd = ($urandom_range(2) == 0); bus.r0_wr = ($urandom_range(3) == 0);
            bus.r1_rd = ($urandom_range(2) == 0); bus.r1_wr = ($urandom_range(3) == 0);
            bus.r0_addr = 16'($urandom); bus.r0_wdata = 16'($urandom);
            bus.r1_addr = 16'($urandom); bus.r1_wdata = 16'($urandom);
            bus.m_busy = 4'($urandom) & 4'($urandom);
            bus.m_err  = ($urandom_range(31) == 0);
         end else begin
            idle_inputs();
         end
         bus.m_rdata = 16'($urandom);
         settle();
         checks++;
         if (obs() !== exp_v) begin
            errors++; $display("FAIL random k=%0d got=%h exp=%h", k, obs(), exp_v);
         end
         advance();
      end
   endtask

   task automatic test_async_reset();
      idle_inputs();
      bus.r0_req = 1; bus.r0_rd = 1; bus.r0_addr = 16'($urandom);
      for (int k = 0; k < 2; k++) begin
         settle();
         checks++;
         if (obs() !== exp_v) begin
            errors++; $display("FAIL arst_setup k=%0d got=%h exp=%h", k, obs(), exp_v);
         end
         advance();
      end
      idle_inputs();
      #1 rst = 1'b1;
      #1;
      checks++;
      if (obs() !== 73'h0) begin
         errors++; $display("FAIL arst_outputs got=%h exp=0", obs());
      end
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      cyc++;
      for (int k = 0; k < RD_LAT + 2; k++) begin
         bus.m_rdata = 16'($urandom);
         settle();
         checks++;
         if ({bus.r0_rvalid, bus.r1_rvalid, obs()} !== {2'b00, exp_v}) begin
            errors++; $display("FAIL arst_no_rvalid k=%0d got=%h exp=%h", k, obs(), exp_v);
         end
         advance();
      end
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      model_reset();
      test_reset();
      test_basic_read();
      test_round_robin();
      test_bank_busy();
      test_drain();
      test_err();
      test_random();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
